ldm_stm_sequencer: RTL

- Multi-cycle sequencer for ARM block transfers (LDM/STM) sitting between the execute stage, data memory and the register file ports.
- Walks a 16-bit register list lowest-to-highest and issues one memory word transfer per set bit.
- On LDM it drives the register-file write port; on STM it drives a register-file read port.
- Optionally writes the updated base address back to the base register.

---
 rtl/ldm_stm_sequencer_if.sv | 68 ++++++
 rtl/ldm_stm_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_sequencer_if.sv
// Bus bundle for the LDM/STM sequencer: execute-stage request, register-file
// ports, data-memory port and status. The slave modport is the sequencer's
// view; the master modport is the surrounding pipeline's view.
// With LDM_STM_ABORT_EN defined, the bundle also carries mem_abort and aborted.
interface ldm_stm_sequencer_if #(
  parameter int WORD_LEN  = 32,
  parameter int REG_COUNT = 16
);
  localparam int IDX_W = $clog2(REG_COUNT);

  logic                 start;
  logic                 is_load;
  logic [REG_COUNT-1:0] reg_list;
  logic [IDX_W-1:0]     base_reg;
  logic [WORD_LEN-1:0]  base_addr;
  logic                 up;
  logic                 pre;
  logic                 write_back;

  logic [IDX_W-1:0]     rf_read_reg;
  logic [WORD_LEN-1:0]  rf_read_data;
  logic                 rf_write_en;
  logic [IDX_W-1:0]     rf_write_reg;
  logic [WORD_LEN-1:0]  rf_write_data;

  logic                 mem_req;
  logic                 mem_we;
  logic [WORD_LEN-1:0]  mem_addr;
  logic [WORD_LEN-1:0]  mem_wdata;
  logic [WORD_LEN-1:0]  mem_rdata;
  logic                 mem_ready;

  logic                 busy;
  logic                 done;

`ifdef LDM_STM_ABORT_EN
  logic                 mem_abort;
  logic                 aborted;
`endif

  modport slave (
`ifdef LDM_STM_ABORT_EN
    input  mem_abort,
    output aborted,
`endif
    input  start, is_load, reg_list, base_reg, base_addr, up, pre, write_back,
    output rf_read_reg,
    input  rf_read_data,
    output rf_write_en, rf_write_reg, rf_write_data,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output busy, done
  );

  modport master (
`ifdef LDM_STM_ABORT_EN
    output mem_abort,
    input  aborted,
`endif
    output start, is_load, reg_list, base_reg, base_addr, up, pre, write_back,
    input  rf_read_reg,
    output rf_read_data,
    input  rf_write_en, rf_write_reg, rf_write_data,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  busy, done
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer. Walks reg_list from the lowest set bit
// upward, issuing one memory word per register at ascending addresses, then
// optionally writes the updated base back to the register file.
// Optional feature: define LDM_STM_ABORT_EN to add mem_abort/aborted, which
// terminate a sequence early without writing the aborted beat or the base.
//
//  state | meaning
//  IDLE  | waiting for start; request fields are latched on start
//  XFER  | one memory beat per remaining register; stalls while mem_ready low
//  WB    | single-cycle base register write-back
//  DONE  | one-cycle done pulse, then back to IDLE
module ldm_stm_sequencer #(
  parameter int WORD_LEN  = 32,
  parameter int REG_COUNT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ldm_stm_sequencer_if.slave    bus
);
  localparam int IDX_W = $clog2(REG_COUNT);
  localparam int CNT_W = $clog2(REG_COUNT + 1);

  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

  state_t               state;
  logic [REG_COUNT-1:0] mask_q;
  logic [IDX_W-1:0]     cur_reg;
  logic [IDX_W-1:0]     base_reg_q;
  logic [WORD_LEN-1:0]  addr_q;
  logic [WORD_LEN-1:0]  final_q;
  logic                 load_q;
  logic                 wb_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 mem_req_q;
  logic                 mem_we_q;
`ifdef LDM_STM_ABORT_EN
  logic                 aborted_q;
`endif

  logic [CNT_W-1:0]     n_start;
  logic [WORD_LEN-1:0]  span;
  logic [WORD_LEN-1:0]  start_addr;
  logic [WORD_LEN-1:0]  final_addr;
  logic                 wb_start;
  logic [REG_COUNT-1:0] mask_clr;
  logic [IDX_W-1:0]     next_idx;
  logic                 beat_ok;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [REG_COUNT-1:0] m);
    lowest_idx = '0;
    for (int i = REG_COUNT - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  // Request decode: transfer count, lowest address of the block, final base,
  // and whether the base write survives (a loaded base register wins).
  always_comb begin
    n_start    = CNT_W'($countones(bus.reg_list));
    span       = WORD_LEN'(n_start) << 2;
    start_addr = bus.base_addr;
    unique case ({bus.up, bus.pre})
      2'b10:   start_addr = bus.base_addr;
      2'b11:   start_addr = bus.base_addr + WORD_LEN'(4);
      2'b00:   start_addr = bus.base_addr - span + WORD_LEN'(4);
      default: start_addr = bus.base_addr - span;
    endcase
    final_addr = bus.up ? (bus.base_addr + span) : (bus.base_addr - span);
    wb_start   = bus.write_back && !(bus.is_load && bus.reg_list[bus.base_reg]);
    mask_clr   = mask_q & ~(REG_COUNT'(1) << cur_reg);
    next_idx   = lowest_idx(mask_clr);
  end

`ifdef LDM_STM_ABORT_EN
  assign beat_ok = bus.mem_ready & ~bus.mem_abort;
`else
  assign beat_ok = bus.mem_ready;
`endif

  // Sequencer FSM with registered status and memory-request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mask_q     <= '0;
      cur_reg    <= '0;
      base_reg_q <= '0;
      addr_q     <= '0;
      final_q    <= '0;
      load_q     <= 1'b0;
      wb_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
`ifdef LDM_STM_ABORT_EN
      aborted_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef LDM_STM_ABORT_EN
      aborted_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.start) begin
            load_q     <= bus.is_load;
            mask_q     <= bus.reg_list;
            base_reg_q <= bus.base_reg;
            final_q    <= final_addr;
            wb_q       <= wb_start;
            busy_q     <= 1'b1;
            if (n_start != '0) begin
              state     <= XFER;
              mem_req_q <= 1'b1;
              mem_we_q  <= !bus.is_load;
              cur_reg   <= lowest_idx(bus.reg_list);
              addr_q    <= start_addr;
            end else if (wb_start) begin
              state <= WB;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        XFER: begin
`ifdef LDM_STM_ABORT_EN
          if (bus.mem_abort) begin
            state     <= DONE;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end else
`endif
          if (bus.mem_ready) begin
            mask_q <= mask_clr;
            addr_q <= addr_q + WORD_LEN'(4);
            if (mask_clr == '0) begin
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              if (wb_q) begin
                state <= WB;
              end else begin
                state  <= DONE;
                done_q <= 1'b1;
              end
            end else begin
              cur_reg <= next_idx;
            end
          end
        end
        WB: begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register-file write port: load data lands in the same cycle the memory
  // accepts the beat; the base write happens in WB.
  always_comb begin
    bus.rf_write_en   = 1'b0;
    bus.rf_write_reg  = '0;
    bus.rf_write_data = '0;
    if (state == XFER && load_q && beat_ok) begin
      bus.rf_write_en   = 1'b1;
      bus.rf_write_reg  = cur_reg;
      bus.rf_write_data = bus.mem_rdata;
    end else if (state == WB) begin
      bus.rf_write_en   = 1'b1;
      bus.rf_write_reg  = base_reg_q;
      bus.rf_write_data = final_q;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.rf_read_reg = cur_reg;
  assign bus.mem_wdata   = mem_we_q ? bus.rf_read_data : '0;
`ifdef LDM_STM_ABORT_EN
  assign bus.aborted     = aborted_q;
`endif
endmodule
